// File: rtl/mul32_seq_if.sv
// Bundles the mul32_seq request/result handshake and the external adder path.
// Purely structural: no timing of its own; all signals are sampled on the owner's clock.
// No backpressure: the requester holds start until busy is seen; the adder is combinational.
interface mul32_seq_if;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] add_a;
   logic [31:0] add_b;
   logic        add_c0;
   logic [32:0] add_s;
   logic        busy;
   logic        done;
   logic [63:0] product;

   // Multiplier side: consumes the request and adder sum, drives adder operands and results.
   modport slave (
      input  start,
      input  a,
      input  b,
      input  add_s,
      output add_a,
      output add_b,
      output add_c0,
      output busy,
      output done,
      output product
   );

   // Environment side: issues requests and closes the loop through the external adder.
   modport master (
      output start,
      output a,
      output b,
      output add_s,
      input  add_a,
      input  add_b,
      input  add_c0,
      input  busy,
      input  done,
      input  product
   );
endinterface

// File: rtl/mul32_seq.sv
// 32x32 unsigned shift-add multiplier driving an external 33-bit-sum adder.
// Latency: start at edge k, done pulse in the cycle after edge k+32; one result per 34 cycles.
// Backpressure: none; start is only sampled in IDLE and ignored while RUN or DONE.
module mul32_seq (
   input  logic        clk,
   input  logic        rst_n,
   mul32_seq_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] m_q, m_d;       // multiplicand
   logic [31:0] q_q, q_d;       // multiplier, shifts right as low product bits enter at the top
   logic [31:0] p_q, p_d;       // partial-product high half
   logic [4:0]  cnt_q, cnt_d;   // step index 0..31
   logic [63:0] prod_q, prod_d; // last completed result

   // State and datapath registers, cleared asynchronously so a mid-run reset aborts at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         m_q     <= '0;
         q_q     <= '0;
         p_q     <= '0;
         cnt_q   <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         q_q     <= q_d;
         p_q     <= p_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
      end
   end

   // Next-state and datapath update; the adder's carry-out becomes P[31] after the shift.
   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      q_d     = q_q;
      p_d     = p_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = RUN;
               m_d     = bus.a;
               q_d     = bus.b;
               p_d     = '0;
               cnt_d   = '0;
               prod_d  = '0;
            end
         end
         RUN: begin
            p_d   = bus.add_s[32:1];
            q_d   = {bus.add_s[0], q_q[31:1]};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = DONE;
               prod_d  = {bus.add_s[32:1], bus.add_s[0], q_q[31:1]};
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Adder operands: B is gated to zero outside RUN so the adder stays quiet when idle.
   assign bus.add_a   = p_q;
   assign bus.add_b   = ((state_q == RUN) && q_q[0]) ? m_q : 32'd0;
   assign bus.add_c0  = 1'b0;

   assign bus.busy    = (state_q == RUN);
   assign bus.done    = (state_q == DONE);
   assign bus.product = prod_q;

endmodule

// File: tb/tb_mul32_seq.sv
module tb_mul32_seq;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   mul32_seq_if bus ();

   mul32_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // External adder model closing the loop.
   assign bus.add_s = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {32'd0, bus.add_c0};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation from IDLE and check latency, busy length, done pulse and result.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                         input string nm);
      int   edges;
      int   busy_n;
      bit   got;
      bit   b0ok;
      bus.a     = a;
      bus.b     = b;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.a     = $urandom;
      bus.b     = $urandom;
      edges  = 0;
      busy_n = 0;
      got    = 1'b0;
      b0ok   = 1'b1;
      while (!got && edges < 40) begin
         if (bus.busy) busy_n++;
         if (bus.busy && bus.add_b != 32'd0) b0ok = 1'b0;
         tick();
         edges++;
         if (bus.done) got = 1'b1;
      end
      chk({nm, " done_seen"}, 64'(got), 64'd1);
      chk({nm, " latency"}, 64'(edges), 64'd32);
      chk({nm, " busy_cycles"}, 64'(busy_n), 64'd32);
      chk({nm, " product"}, bus.product, exp);
      chk({nm, " add_b_in_done"}, 64'(bus.add_b), 64'd0);
      if (b == 32'd0) chk({nm, " add_b_zero_run"}, 64'(b0ok), 64'd1);
      tick();
      chk({nm, " done_pulse_end"}, 64'(bus.done), 64'd0);
      chk({nm, " product_held"}, bus.product, exp);
   endtask

   initial begin
      int dones;
      int last_edge;
      int nd;
      logic [63:0] cap;

      errors = 0;
      checks = 0;
      vecs[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F};
      vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
      vecs[2] = '{32'h1234_5678,  32'd0,          64'h0};
      vecs[3] = '{32'd0,          32'hFFFF_FFFF,  64'h0};
      vecs[4] = '{32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000};
      vecs[5] = '{32'hFFFF_FFFF,  32'd2,          64'h0000_0001_FFFF_FFFE};
      vecs[6] = '{32'h8000_0001,  32'd3,          64'h0000_0001_8000_0003};
      vecs[7] = '{32'h0000_FFFF,  32'h0000_FFFF,  64'h0000_0000_FFFE_0001};
      vecs[8] = '{32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000};
      vecs[9] = '{32'hFFFF_FFFF,  32'h8000_0000,  64'h7FFF_FFFF_8000_0000};

      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      rst_n     = 1'b1;
      #1 rst_n  = 1'b0;
      #2;
      chk("rst busy",    64'(bus.busy),    64'd0);
      chk("rst done",    64'(bus.done),    64'd0);
      chk("rst product", bus.product,      64'd0);
      chk("rst add_a",   64'(bus.add_a),   64'd0);
      chk("rst add_b",   64'(bus.add_b),   64'd0);
      chk("rst add_c0",  64'(bus.add_c0),  64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Table-driven vectors, issued back to back.
      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
      end

      // Start re-pulsed at RUN cycle 10 must be ignored.
      bus.a     = 32'h0000_1234;
      bus.b     = 32'h0000_0100;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      bus.a     = 32'd7;
      bus.b     = 32'd7;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      dones = 0;
      cap   = '0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.done) begin
            dones++;
            cap = bus.product;
         end
      end
      chk("ignore_start dones",   64'(dones), 64'd1);
      chk("ignore_start product", cap,        64'h0000_0000_0012_3400);
      chk("ignore_start busy",    64'(bus.busy), 64'd0);

      // Asynchronous reset in the middle of a run.
      bus.a     = 32'hFFFF_FFFF;
      bus.b     = 32'hFFFF_FFFF;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 16; i++) tick();
      chk("midrun busy_before", 64'(bus.busy), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrun rst busy",    64'(bus.busy),  64'd0);
      chk("midrun rst product", bus.product,    64'd0);
      chk("midrun rst add_a",   64'(bus.add_a), 64'd0);
      chk("midrun rst done",    64'(bus.done),  64'd0);
      #1 rst_n = 1'b1;
      tick();
      chk("post_rst idle", 64'(bus.busy), 64'd0);
      run_op(32'd2, 32'd9, 64'd18, "post_rst");

      // Start held high: one result every 34 cycles.
      bus.a     = 32'h0001_0000;
      bus.b     = 32'h0001_0000;
      bus.start = 1'b1;
      tick();
      nd        = 0;
      last_edge = 0;
      for (int e = 1; e <= 120 && nd < 3; e++) begin
         tick();
         if (bus.done) begin
            chk($sformatf("held done%0d product", nd), bus.product, 64'h0000_0001_0000_0000);
            if (nd == 0) chk("held first latency", 64'(e), 64'd32);
            else         chk($sformatf("held interval%0d", nd), 64'(e - last_edge), 64'd34);
            last_edge = e;
            nd++;
            if (nd == 3) bus.start = 1'b0;
         end
      end
      chk("held done count", 64'(nd), 64'd3);
      bus.start = 1'b0;
      tick();
      tick();
      chk("held stop idle", 64'(bus.busy), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
